jt12_wr_sched: RTL and testbench
================================

// Module: jt12_wr_sched
// PURPOSE
//  Host-side write scheduler for the jt12 register bank. Buffers CPU address/data writes in a FIFO.
//  Decodes each write into one register-bank update strobe with ch/op/din.
//  Holds each strobe for one full slot rotation so every time-multiplexed op/ch slot sees it.
//  Sits between the CPU bus and the register bank; drives the bank's up_*, din, ch, op and latch_fnum inputs, and reports busy.
// PARAMETERS
//  num_ch   6  channel count: 6 (YM2612/YM2608) or 3 (YM2203/YM2610); HOLD = 4*num_ch clk_en ticks
//  FIFO_DW  2  log2 FIFO depth (depth 4)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  clk_en      in   1  slot-advance enable, same enable as the register bank
//  cpu_wr      in   1  one-cycle write strobe
//  cpu_addr    in   2  [0]=A0 (0 addr, 1 data), [1]=A1 (part)
//  cpu_din     in   8  CPU data
//  busy        out  1  FIFO non-empty or FSM not IDLE
//  ovf         out  1  sticky: data write dropped on full FIFO
//  din         out  8  data to the register bank
//  ch          out  3  target channel {part,addr[1:0]}
//  op          out  2  target operator = addr[3:2] (00 S1, 01 S3, 10 S2, 11 S4)
//  latch_fnum  out  6  {block,fnum_hi} from 0xA4-0xA6
//  up_keyon, up_alg, up_fnumlo, up_pms, up_dt1, up_tl, up_ks_ar, up_amen_dr,
//  up_sr, up_sl_rr, up_ssgeg   out  1 each  update strobes, at most one high
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, address latch 0. Async assert, sync release.
//  Address write (cpu_wr & ~A0): latch {A1,cpu_din}. No FIFO push.
//  Data write (cpu_wr & A0): push {latched addr(9b), cpu_din}. If full, drop it and set ovf.
//  Simultaneous push and pop are legal; occupancy is unchanged.
//  Pointers wrap modulo depth; full = count==depth.
//  FSM states are IDLE, DEC and HOLD. All transitions occur on clk (not gated by clk_en).
//   IDLE: if FIFO non-empty, pop into the entry register and go to DEC; otherwise stay in IDLE.
//   DEC: decode the popped entry (decode map below).
//    - Valid strobe register: load din/ch/op, clear hcnt, go to HOLD.
//    - 0xA4-0xA6: latch_fnum<=din[5:0] and return to IDLE (no strobe).
//    - Discarded entry: return to IDLE.
//   HOLD: strobe is high. hcnt increments on each clk_en.
//    - The clock on which clk_en is high with hcnt==HOLD-1 drops the strobe and moves to IDLE.
//    - Strobe width is exactly HOLD clk_en ticks. A gap of at least one IDLE cycle always follows.
//  din/ch/op remain stable from DEC exit until the next DEC.
//  Decode map (addr[7:0]; part=addr[8]). Op regs require addr[1:0]!=3, else discard:
//   0x30 dt1 | 0x40 tl | 0x50 ks_ar | 0x60 amen_dr | 0x70 sr | 0x80 sl_rr | 0x90 ssgeg
//   Channel regs, addr[3:0] in {0,1,2}, else discard: 0xA0 fnumlo | 0xA4 fnum-hi latch | 0xB0 alg | 0xB4 pms
//   0x28 (part 0 only): up_keyon; ch/op=0.
//   Anything else, and any part=1 entry when num_ch==3: discarded, nothing driven.
//  Latency: data write at clock N with empty FIFO and IDLE -> pop N+1 -> DEC N+2 -> strobe high from N+3.
//  clk_en low for the whole HOLD: strobe stays high indefinitely; no timeout.
//  busy falls on the clock the FSM enters IDLE with the FIFO empty.
// TESTING
//  1. clk_en=1; write A=0x40, D=0x7F -> up_tl high exactly 24 clocks; din=0x7F, ch=0, op=0; busy low 1 clock later.
//  2. A1=1, A=0x36, D=0x71 -> up_dt1 with ch=6, op=1; A=0x3F write -> discarded, no strobe, busy clears in 3 clocks.
//  3. Write 0xA4=0x22 then 0xA0=0x55 -> latch_fnum=0x22 before up_fnumlo rises; din=0x55 held 24 ticks.
//  4. 6 back-to-back data writes, depth 4 -> first popped; 4 queued; 6th dropped, ovf=1.
//     5 strobes are issued in order, each 24 ticks, separated by 1 IDLE cycle.
//  5. clk_en every 3rd clock, 0x28=0xF0 -> up_keyon width 72 clocks. Assert rst_n=0 mid-HOLD -> strobe, busy, ovf 0 immediately.
//  6. num_ch=3: part-1 write to 0xB0 -> dropped. 0xB2=0x3A -> up_alg with ch=2; strobe width 12 ticks.

Source files
------------

// File: rtl/jt12_wr_sched_if.sv
// CPU-side bus of the jt12 write scheduler.
// Handshake: cpu_wr is a one-cycle write strobe with no ready. Every write is
// taken on the clock it is presented; a data write that finds the FIFO full is
// dropped and raises the sticky ovf flag. busy tells the host that queued or
// in-flight writes have not yet reached the register bank.
interface jt12_wr_sched_if;
    logic       cpu_wr;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       busy;
    logic       ovf;

    modport master (output cpu_wr, cpu_addr, cpu_din, input busy, ovf);
    modport slave  (input cpu_wr, cpu_addr, cpu_din, output busy, ovf);
endinterface

// File: rtl/jt12_wr_sched.sv
// Host write scheduler for the jt12 register bank: queues CPU writes, decodes
// each into a single update strobe and holds it for one full slot rotation.
module jt12_wr_sched #(
    parameter int num_ch  = 6,
    parameter int FIFO_DW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    jt12_wr_sched_if.slave bus,
    output logic [7:0] din,
    output logic [2:0] ch,
    output logic [1:0] op,
    output logic [5:0] latch_fnum,
    output logic       up_keyon,
    output logic       up_alg,
    output logic       up_fnumlo,
    output logic       up_pms,
    output logic       up_dt1,
    output logic       up_tl,
    output logic       up_ks_ar,
    output logic       up_amen_dr,
    output logic       up_sr,
    output logic       up_sl_rr,
    output logic       up_ssgeg,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, DEC = 2'd1, HOLD = 2'd2} state_t;

    localparam int               DEPTH     = 1 << FIFO_DW;
    localparam logic [FIFO_DW:0] DEPTH_C   = (FIFO_DW + 1)'(DEPTH);
    localparam logic [4:0]       HOLD_LAST = 5'(4 * num_ch - 1);
    localparam bit               THREE_CH  = (num_ch == 3);

    // One-hot strobe positions: bit0 keyon, 1 alg, 2 fnumlo, 3 pms, 4..10 are
    // the operator registers 0x30..0x90 in address order.
    localparam logic [10:0] S_KEYON  = 11'h001;
    localparam logic [10:0] S_ALG    = 11'h002;
    localparam logic [10:0] S_FNUMLO = 11'h004;
    localparam logic [10:0] S_PMS    = 11'h008;

    state_t              state, state_nx;
    logic [1:0]          rst_sync;
    logic                rst_i;
    logic [8:0]          addr_q;
    logic [16:0]         mem [DEPTH];
    logic [FIFO_DW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_DW:0]    cnt;
    logic                full, empty, data_wr, push, pop;
    logic                ovf_q;
    logic [16:0]         entry_q;
    logic [4:0]          hcnt;
    logic [10:0]         sel_q, stb;
    logic [10:0]         dec_sel;
    logic [2:0]          dec_ch;
    logic [1:0]          dec_op;
    logic                dec_latch;
    logic [7:0]          e_a, e_d;
    logic                e_part;

    // Reset: asserts asynchronously, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign data_wr = bus.cpu_wr & bus.cpu_addr[0];
    assign push    = data_wr & ~full;
    assign pop     = (state == IDLE) & ~empty;

    // Address latch: part bit plus register address from address writes.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i)                               addr_q <= '0;
        else if (bus.cpu_wr && !bus.cpu_addr[0])  addr_q <= {bus.cpu_addr[1], bus.cpu_din};
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {addr_q, bus.cpu_din};
    end

    // FIFO pointers, occupancy, overflow flag and popped entry.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ovf_q   <= 1'b0;
            entry_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                entry_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (data_wr && full) ovf_q <= 1'b1;
        end
    end

    assign e_part = entry_q[16];
    assign e_a    = entry_q[15:8];
    assign e_d    = entry_q[7:0];

    // Decode the popped entry into a strobe selection and its ch/op target.
    // Channel registers carry no operator, so op is left at 0 for them.
    always_comb begin
        dec_sel   = '0;
        dec_ch    = {e_part, e_a[1:0]};
        dec_op    = 2'b00;
        dec_latch = 1'b0;
        if (!(e_part && THREE_CH)) begin
            if (e_a == 8'h28) begin
                if (!e_part) begin
                    dec_sel = S_KEYON;
                    dec_ch  = 3'd0;
                end
            end else if (e_a[7:4] >= 4'h3 && e_a[7:4] <= 4'h9) begin
                if (e_a[1:0] != 2'd3) begin
                    dec_sel = 11'd1 << (e_a[7:4] + 4'd1);
                    dec_op  = e_a[3:2];
                end
            end else if ((e_a[7:4] == 4'hA || e_a[7:4] == 4'hB) && !e_a[3] && e_a[1:0] != 2'd3) begin
                case ({e_a[4], e_a[2]})
                    2'b00:   dec_sel   = S_FNUMLO;
                    2'b01:   dec_latch = 1'b1;
                    2'b10:   dec_sel   = S_ALG;
                    default: dec_sel   = S_PMS;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next state.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = DEC;
            DEC:     state_nx = (|dec_sel) ? HOLD : IDLE;
            HOLD:    if (clk_en && hcnt == HOLD_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bank-side data registers and hold counter; din/ch/op change only in DEC.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            din        <= '0;
            ch         <= '0;
            op         <= '0;
            latch_fnum <= '0;
            sel_q      <= '0;
            hcnt       <= '0;
        end else if (state == DEC) begin
            if (|dec_sel) begin
                sel_q <= dec_sel;
                din   <= e_d;
                ch    <= dec_ch;
                op    <= dec_op;
                hcnt  <= '0;
            end
            if (dec_latch) latch_fnum <= e_d[5:0];
        end else if (state == HOLD && clk_en) begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // FSM outputs: the selected strobe is high exactly while in HOLD.
    always_comb begin
        stb = (state == HOLD) ? sel_q : 11'd0;
    end

    assign up_keyon   = stb[0];
    assign up_alg     = stb[1];
    assign up_fnumlo  = stb[2];
    assign up_pms     = stb[3];
    assign up_dt1     = stb[4];
    assign up_tl      = stb[5];
    assign up_ks_ar   = stb[6];
    assign up_amen_dr = stb[7];
    assign up_sr      = stb[8];
    assign up_sl_rr   = stb[9];
    assign up_ssgeg   = stb[10];
    assign bus.busy   = ~empty | (state != IDLE);
    assign bus.ovf    = ovf_q;
    assign state_dbg  = state;
endmodule

// File: tb/tb_jt12_wr_sched.sv
// Bench for jt12_wr_sched: a 6-channel and a 3-channel instance.
module tb_jt12_wr_sched;
    localparam int EW = 30;   // {strobe(11), din(8), ch(3), op(2), latch_fnum(6)}
    localparam logic [10:0] KEYON = 11'h001, ALG = 11'h002, FNUMLO = 11'h004, PMS = 11'h008;
    localparam logic [10:0] DT1 = 11'h010, TL = 11'h020, KSAR = 11'h040, AMDR = 11'h080;
    localparam logic [10:0] SR = 11'h100, SLRR = 11'h200, SSG = 11'h400;

    typedef struct {
        logic       a1;
        logic [7:0] addr;
        logic [7:0] data;
        logic [10:0] stb;
        logic [2:0] ch;
        logic [1:0] op;
        logic [5:0] lat;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
    int   en_div = 1, en_cnt = 0;
    int   errors = 0, checks = 0;
    int   exp_ticks = 24;
    logic [EW-1:0] exp_q[$];

    jt12_wr_sched_if bus6();
    jt12_wr_sched_if bus3();

    logic [7:0] din6, din3;
    logic [2:0] ch6, ch3;
    logic [1:0] op6, op3, st6, st3;
    logic [5:0] lat6, lat3;
    logic [10:0] s6, s3, prev6;
    int hi_tick;

    jt12_wr_sched #(.num_ch(6), .FIFO_DW(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus6),
        .din(din6), .ch(ch6), .op(op6), .latch_fnum(lat6),
        .up_keyon(s6[0]), .up_alg(s6[1]), .up_fnumlo(s6[2]), .up_pms(s6[3]),
        .up_dt1(s6[4]), .up_tl(s6[5]), .up_ks_ar(s6[6]), .up_amen_dr(s6[7]),
        .up_sr(s6[8]), .up_sl_rr(s6[9]), .up_ssgeg(s6[10]), .state_dbg(st6)
    );

    jt12_wr_sched #(.num_ch(3), .FIFO_DW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus3),
        .din(din3), .ch(ch3), .op(op3), .latch_fnum(lat3),
        .up_keyon(s3[0]), .up_alg(s3[1]), .up_fnumlo(s3[2]), .up_pms(s3[3]),
        .up_dt1(s3[4]), .up_tl(s3[5]), .up_ks_ar(s3[6]), .up_amen_dr(s3[7]),
        .up_sr(s3[8]), .up_sl_rr(s3[9]), .up_ssgeg(s3[10]), .state_dbg(st3)
    );

    // Clock and clk_en (every en_div-th clock, changed just after the edge).
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        en_cnt = (en_cnt + 1) % en_div;
        clk_en = (en_cnt == 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Driver: one bus cycle on the chosen instance.
    task automatic wr(input int which, input logic a0, input logic a1, input logic [7:0] d);
        @(negedge clk);
        if (which == 3) begin
            bus3.cpu_wr = 1'b1; bus3.cpu_addr = {a1, a0}; bus3.cpu_din = d;
        end else begin
            bus6.cpu_wr = 1'b1; bus6.cpu_addr = {a1, a0}; bus6.cpu_din = d;
        end
        @(posedge clk);
        #1;
        bus3.cpu_wr = 1'b0;
        bus6.cpu_wr = 1'b0;
    endtask

    task automatic wait_idle6(input int budget);
        bit done = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!bus6.busy && s6 == 0) begin done = 1; break; end
        end
        if (!done) timeout("idle6");
    endtask

    // Scoreboard: every strobe rise pops one expected record; width in clk_en ticks.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            prev6   = '0;
            hi_tick = 0;
        end else begin
            if (s6 != 0 && prev6 == 0) begin
                hi_tick = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got %0h expected none", s6);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_rec", {s6, din6, ch6, op6, lat6}, e);
                end
                chk("onehot", $onehot(s6), 1);
            end
            if (s6 != 0 && clk_en) hi_tick++;
            if (s6 == 0 && prev6 != 0) chk("width_ticks", hi_tick, exp_ticks);
            prev6 = s6;
        end
    end

    initial begin
        vec_t vecs[19];
        int   lat, n, any;
        bit   seen;

        vecs[0]  = '{1'b0, 8'h40, 8'h7F, TL,     3'd0, 2'd0, 6'h00};
        vecs[1]  = '{1'b1, 8'h36, 8'h71, DT1,    3'd6, 2'd1, 6'h00};
        vecs[2]  = '{1'b0, 8'h3F, 8'h12, 11'd0,  3'd0, 2'd0, 6'h00};
        vecs[3]  = '{1'b0, 8'hA4, 8'h22, 11'd0,  3'd0, 2'd0, 6'h00};
        vecs[4]  = '{1'b0, 8'hA0, 8'h55, FNUMLO, 3'd0, 2'd0, 6'h22};
        vecs[5]  = '{1'b0, 8'h28, 8'hF0, KEYON,  3'd0, 2'd0, 6'h22};
        vecs[6]  = '{1'b1, 8'h28, 8'h11, 11'd0,  3'd0, 2'd0, 6'h22};
        vecs[7]  = '{1'b0, 8'h5D, 8'hAB, KSAR,   3'd1, 2'd3, 6'h22};
        vecs[8]  = '{1'b1, 8'h96, 8'h0F, SSG,    3'd6, 2'd1, 6'h22};
        vecs[9]  = '{1'b0, 8'hB2, 8'h3A, ALG,    3'd2, 2'd0, 6'h22};
        vecs[10] = '{1'b0, 8'hB5, 8'h07, PMS,    3'd1, 2'd0, 6'h22};
        vecs[11] = '{1'b0, 8'hB8, 8'h01, 11'd0,  3'd0, 2'd0, 6'h22};
        vecs[12] = '{1'b0, 8'h10, 8'h01, 11'd0,  3'd0, 2'd0, 6'h22};
        vecs[13] = '{1'b0, 8'h62, 8'h80, AMDR,   3'd2, 2'd0, 6'h22};
        vecs[14] = '{1'b0, 8'h7C, 8'h1F, SR,     3'd0, 2'd3, 6'h22};
        vecs[15] = '{1'b0, 8'h81, 8'hFF, SLRR,   3'd1, 2'd0, 6'h22};
        vecs[16] = '{1'b1, 8'hA6, 8'h3C, 11'd0,  3'd0, 2'd0, 6'h22};
        vecs[17] = '{1'b1, 8'hA1, 8'h99, FNUMLO, 3'd5, 2'd0, 6'h3C};
        vecs[18] = '{1'b0, 8'h4B, 8'h00, 11'd0,  3'd0, 2'd0, 6'h3C};

        bus6.cpu_wr = 1'b0; bus6.cpu_addr = 2'b00; bus6.cpu_din = 8'h00;
        bus3.cpu_wr = 1'b0; bus3.cpu_addr = 2'b00; bus3.cpu_din = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {s6, din6, ch6, op6, lat6, bus6.busy, bus6.ovf, st6}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset", {s6, s3, bus6.busy, bus3.busy, bus6.ovf, st6, st3}, 64'd0);

        // Table-driven single writes, clk_en always high.
        foreach (vecs[i]) begin
            wr(6, 1'b0, vecs[i].a1, vecs[i].addr);
            wr(6, 1'b1, vecs[i].a1, vecs[i].data);
            if (vecs[i].stb != 0) begin
                exp_q.push_back({vecs[i].stb, vecs[i].data, vecs[i].ch, vecs[i].op, vecs[i].lat});
                lat = 0;
                for (int k = 1; k <= 6; k++) begin
                    @(negedge clk);
                    if (s6 != 0) begin lat = k; break; end
                end
                chk("latency", lat, 3);
            end else begin
                n = 0;
                for (int k = 1; k <= 6; k++) begin
                    @(negedge clk);
                    if (bus6.busy) n++;
                    else break;
                end
                chk("discard_busy_cycles", n, 2);
            end
            wait_idle6(100);
        end
        chk("ovf_clear", bus6.ovf, 0);
        chk("queue_empty_1", exp_q.size(), 0);

        // Six back-to-back data writes into a depth-4 FIFO.
        wr(6, 1'b0, 1'b0, 8'h40);
        for (int j = 0; j < 6; j++) begin
            wr(6, 1'b1, 1'b0, 8'(8'h10 + j));
            if (j < 5) exp_q.push_back({TL, 8'(8'h10 + j), 3'd0, 2'd0, 6'h3C});
        end
        @(negedge clk);
        chk("ovf_set", bus6.ovf, 1);
        wait_idle6(400);
        chk("queue_empty_2", exp_q.size(), 0);
        chk("ovf_sticky", bus6.ovf, 1);

        // Sparse clk_en: strobe width counted in ticks, then reset mid-HOLD.
        en_div = 3;
        wr(6, 1'b0, 1'b0, 8'h28);
        wr(6, 1'b1, 1'b0, 8'hF0);
        exp_q.push_back({KEYON, 8'hF0, 3'd0, 2'd0, 6'h3C});
        wait_idle6(200);
        wr(6, 1'b1, 1'b0, 8'h0F);
        exp_q.push_back({KEYON, 8'h0F, 3'd0, 2'd0, 6'h3C});
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s6 != 0) begin seen = 1; break; end
        end
        if (!seen) timeout("keyon_rise");
        repeat (30) @(negedge clk);
        chk("keyon_mid_hold", s6, KEYON);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {s6, bus6.busy, bus6.ovf, st6}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en_div = 1;
        repeat (4) @(posedge clk);

        // 3-channel instance: part 1 dropped, 12-tick strobe.
        wr(3, 1'b0, 1'b1, 8'hB0);
        wr(3, 1'b1, 1'b1, 8'h44);
        any = 0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (s3 != 0) any = 1;
            if (bus3.busy) n++;
        end
        chk("ch3_part1_strobe", any, 0);
        chk("ch3_part1_busy", n, 2);
        wr(3, 1'b0, 1'b0, 8'hB2);
        wr(3, 1'b1, 1'b0, 8'h3A);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s3 != 0) begin seen = 1; break; end
        end
        if (!seen) timeout("ch3_alg_rise");
        chk("ch3_alg", {s3, din3, ch3}, {ALG, 8'h3A, 3'd2});
        n = 0;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (s3 == 0) begin seen = 1; break; end
            n++;
            @(negedge clk);
        end
        if (!seen) timeout("ch3_alg_fall");
        chk("ch3_width", n, 12);
        chk("queue_empty_3", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
